// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One dabble iteration is performed per clock. The packed BCD result is held
// in an output register and only changes when a conversion completes or on
// reset. DIGITS must be large enough that 10^DIGITS > 2^BIN_W - 1, otherwise
// the top digit cannot hold the most significant decimal place.
module binary_to_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    // Working register layout: {BCD digits, remaining binary bits}.
    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORK_W-1:0]   adjusted;
    logic [WORK_W-1:0]   stepped;

    // One dabble iteration: add 3 to every digit >= 5, then shift left by one.
    always_comb begin
        adjusted = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*i +: 4] = work_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        stepped = {adjusted[WORK_W-2:0], 1'b0};
    end

    // Next-state logic for the converter FSM and its registered outputs.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {{BCD_W{1'b0}}, bin};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = stepped;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = work_q[WORK_W-1 -: BCD_W];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed self-checking bench for binary_to_bcd (default 8-bit / 3 digits).
module tb_binary_to_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int expDone     = 0;

    binary_to_bcd #(.BIN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Decimal digits of a byte, packed as BCD.
    function automatic logic [11:0] toBcd(input int value);
        logic [3:0] h, t, o;
        h = 4'(value / 100);
        t = 4'((value / 10) % 10);
        o = 4'(value % 10);
        return {h, t, o};
    endfunction

    // Issue a start (caller is #1 past a rising edge), scramble bin after
    // acceptance, wait for done and check latency, hold and result.
    // Returns #1 after the edge that raised done.
    task automatic applyStimulus(input logic [7:0] value, input logic [11:0] expBcd,
                                 input string tag);
        int          cycles;
        logic [11:0] prevBcd;
        logic        holdOk;
        prevBcd = bcd;
        holdOk  = 1'b1;
        start   = 1'b1;
        bin     = value;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin    = ~value;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (bcd !== prevBcd) holdOk = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        expDone++;
        checkOutput({tag, " latency"}, 32'(cycles), 32'd9);
        checkOutput({tag, " hold"}, {31'd0, holdOk}, 32'd1);
        checkOutput({tag, " bcd"}, {20'd0, bcd}, {20'd0, expBcd});
    endtask

    initial begin
        int cycles;
        start = 1'b0;
        bin   = 8'd0;
        rst_n = 1'b0;
        #1;
        checkOutput("reset bcd", {20'd0, bcd}, 32'h000);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero: same latency, busy low the cycle after done.
        applyStimulus(8'd0, 12'h000, "bin0");
        @(posedge clk);
        #1;
        checkOutput("bin0 busy after done", {31'd0, busy}, 32'd0);
        checkOutput("bin0 done one cycle", {31'd0, done}, 32'd0);

        // Directed boundaries.
        applyStimulus(8'd255, 12'h255, "bin255");
        applyStimulus(8'd99,  12'h099, "bin99");
        applyStimulus(8'd100, 12'h100, "bin100");
        applyStimulus(8'd9,   12'h009, "bin9");
        applyStimulus(8'd10,  12'h010, "bin10");

        // Exhaustive sweep, each start issued right after the previous done.
        for (int v = 0; v < 256; v++) begin
            applyStimulus(8'(v), toBcd(v), "sweep");
        end
        @(posedge clk);
        #1;

        // Start while busy is ignored; bin changes have no effect.
        start = 1'b1;
        bin   = 8'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 8'd17;
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (cycles == 2) begin
                start = 1'b1;
                bin   = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        expDone++;
        checkOutput("ignore latency", 32'(cycles), 32'd9);
        checkOutput("ignore bcd", {20'd0, bcd}, 32'h042);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("ignore busy idle", {31'd0, busy}, 32'd0);
        checkOutput("ignore done count", 32'(doneCount), 32'(expDone));
        checkOutput("ignore bcd kept", {20'd0, bcd}, 32'h042);

        // Asynchronous reset mid-conversion.
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort busy before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort bcd", {20'd0, bcd}, 32'h000);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("abort no done", 32'(doneCount), 32'(expDone));
        checkOutput("abort busy idle", {31'd0, busy}, 32'd0);
        applyStimulus(8'd77, 12'h077, "after abort");

        // Result holds through a following conversion until its done.
        @(posedge clk);
        #1;
        applyStimulus(8'd255, 12'h255, "hold prep");
        @(posedge clk);
        #1;
        applyStimulus(8'd5, 12'h005, "hold 5");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("total done count", 32'(doneCount), 32'(expDone));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one iteration per clock.
- Converts an unsigned BIN_W-bit value to DIGITS packed BCD digits.
- Feeds display/decimal-formatting logic.
- The result is held in an output register until the next conversion completes.

Parameters:
- BIN_W, 8, width of the unsigned binary input.
- DIGITS, 3, number of BCD digits out. Must satisfy 10^DIGITS > 2^BIN_W - 1.
- Default pairing covers 0..255 to 000..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion of bin; honoured only when idle.
- bin  input  BIN_W  unsigned binary value, sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  single-cycle pulse: bcd has just been updated.
- bcd  output  4*DIGITS  packed BCD result.
  - bcd[3:0] = ones, bcd[7:4] = tens, bcd[11:8] = hundreds (default).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bcd=0, done=0, busy=0, iteration counter=0, working register=0.
- Reset mid-conversion aborts the conversion. No done pulse follows release.
- States:
  - IDLE: wait for start.
  - SHIFT: one double-dabble iteration per clock.
  - DONE: publish the result.
- IDLE with start=1 at edge k:
  - Working register = {DIGITS*4 zeros, bin}; counter=0; go to SHIFT.
  - bin is not sampled again during the conversion.
- SHIFT, each edge, as one combinational step:
  - Every BCD nibble of the working register that is >=5 gets +3.
  - Then the whole register shifts left by 1; counter increments.
  - After BIN_W iterations (edges k+1..k+BIN_W), go to DONE.
- DONE (edge k+BIN_W+1):
  - bcd <= BCD field of the working register.
  - done=1 for exactly this one cycle.
  - Return to IDLE.
- Latency: done and the new bcd are visible BIN_W+1 cycles after the start-accepting edge (9 for the default).
- Throughput: one conversion per BIN_W+2 cycles.
- busy is high from edge k through the DONE cycle; low in IDLE.
- start while busy, including the DONE cycle, is ignored. It is not queued.
- bcd changes only in DONE or on reset. It holds its previous value throughout a conversion.
- Every output nibble is always in the range 0..9. No overflow is possible given the DIGITS constraint.
- bin=0 produces bcd=0 with the same latency. There is no early termination.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then start with bin=8'd0 -> done after 9 cycles, bcd=12'h000, busy low the cycle after done.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> bcd=12'h099. bin=8'd100 -> bcd=12'h100. bin=8'd9 -> 12'h009. bin=8'd10 -> 12'h010.
- Exhaustive sweep 0..255, back-to-back starts issued the cycle after each done:
  - each bcd equals the decimal digits of bin;
  - no nibble ever exceeds 9;
  - exactly one done pulse per start.
- Start bin=8'd42, then pulse start with bin=8'd200 three cycles later:
  - single done, bcd=12'h042;
  - second start is ignored;
  - bin changes during the conversion have no effect.
- Start bin=8'd123, assert rst_n low at cycle 4:
  - bcd=0, busy=0, done=0 immediately (asynchronous);
  - no done after release;
  - a new start with bin=8'd77 gives bcd=12'h077.
- Hold bcd=12'h255, then start bin=8'd5 -> bcd stays 12'h255 until the done cycle, then becomes 12'h005.
